pc_gen_pipe: RTL and testbench

Parametrised program-counter generator for the multi-stage RV32I pipelines. It produces the fetch address and holds it under load/imem stalls. It applies branch, jump and jalr redirects with fixed priority and keeps a HIST_DEPTH-deep history of issued PCs for downstream stages. It also raises a one-cycle flush on redirect, traps misaligned targets and counts stall cycles.

---
 rtl/pc_gen_pipe_if.sv | 37 +++
 rtl/pc_gen_pipe.sv | 122 ++++++++++++
 tb/tb_pc_gen_pipe.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_pipe_if.sv
// Fetch-side bundle for the PC generator: redirect/stall
// requests in, fetch address, history and status out.
interface pc_gen_pipe_if #(
  parameter int ADDR_W     = 32,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 16
) ();
  logic                         next_sel;
  logic                         branch_result;
  logic                         jalr;
  logic [ADDR_W-1:0]            next_address;
  logic                         load;
  logic                         dmem_valid;
  logic                         imem_ready;
  logic [ADDR_W-1:0]            pc_out;
  logic                         pc_valid;
  logic [HIST_DEPTH*ADDR_W-1:0] hist_out;
  logic                         flush;
  logic                         misalign_err;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output next_sel, branch_result, jalr,
    output next_address, load, dmem_valid,
    output imem_ready,
    input  pc_out, pc_valid, hist_out,
    input  flush, misalign_err, stall_cnt
  );

  modport slave (
    input  next_sel, branch_result, jalr,
    input  next_address, load, dmem_valid,
    input  imem_ready,
    output pc_out, pc_valid, hist_out,
    output flush, misalign_err, stall_cnt
  );
endinterface

// File: rtl/pc_gen_pipe.sv
// Program-counter generator: prioritised redirects, stall hold,
// PC history, flush pulse, misalignment trap and stall counter.
module pc_gen_pipe #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INC        = 4,
  parameter int                HIST_DEPTH = 2,
  parameter int                ALIGN_BITS = 2,
  parameter int                CNT_W      = 16
) (
  input logic          clk,
  input logic          rst,
  pc_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_hist [HIST_DEPTH];
  logic              r_valid;
  logic              r_flush;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_run;
  logic              w_redir;
  logic              w_take;
  logic [ADDR_W-1:0] w_tgt;
  logic              w_mis;
  logic              w_stall;
  logic              w_adv;
  logic              w_shift;
  logic [ADDR_W-1:0] w_pc_inc;

  logic [HIST_DEPTH*ADDR_W-1:0] w_hist_flat;

  assign w_run    = (r_state == RUN);
  assign w_redir  = bus.next_sel | bus.branch_result;
  assign w_take   = w_run & (w_redir | bus.jalr);
  assign w_pc_inc = r_pc + ADDR_W'(INC);

  // Plain redirects outrank jalr; only jalr drops bit 0.
  assign w_tgt = w_redir
               ? bus.next_address
               : {bus.next_address[ADDR_W-1:1], 1'b0};

  assign w_mis   = w_take & (|w_tgt[ALIGN_BITS-1:0]);
  assign w_stall = w_run & ~w_take &
                   ((bus.load & ~bus.dmem_valid) |
                    ~bus.imem_ready);
  assign w_adv   = w_run & ~w_take & ~w_stall;
  assign w_shift = w_adv | (w_take & ~w_mis);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    w_state_nx = RUN;
      RUN:     if (w_mis) w_state_nx = HALT;
      HALT:    w_state_nx = HALT;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      for (int k = 0; k < HIST_DEPTH; k++)
        r_hist[k] <= '0;
    end else begin
      r_flush <= 1'b0;
      if (r_state == IDLE)
        r_valid <= 1'b1;
      if (w_take && !w_mis) begin
        r_pc    <= w_tgt;
        r_flush <= 1'b1;
      end else if (w_take) begin
        r_err   <= 1'b1;
        r_valid <= 1'b0;
      end else if (w_stall) begin
        if (r_cnt != '1)
          r_cnt <= r_cnt + 1'b1;
      end else if (w_adv) begin
        r_pc <= w_pc_inc;
      end
      if (w_shift) begin
        r_hist[0] <= r_pc;
        for (int k = 1; k < HIST_DEPTH; k++)
          r_hist[k] <= r_hist[k-1];
      end
    end
  end

  always_comb begin
    w_hist_flat = '0;
    for (int k = 0; k < HIST_DEPTH; k++)
      w_hist_flat[k*ADDR_W +: ADDR_W] = r_hist[k];
  end

  assign bus.pc_out       = r_pc;
  assign bus.pc_valid     = r_valid;
  assign bus.hist_out     = w_hist_flat;
  assign bus.flush        = r_flush;
  assign bus.misalign_err = r_err;
  assign bus.stall_cnt    = r_cnt;

endmodule

// File: tb/tb_pc_gen_pipe.sv
// Directed bench for pc_gen_pipe: default, 1-bit-align and
// wrap-around instances checked against hand-computed values.
module tb_pc_gen_pipe;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_gen_pipe_if #(.ADDR_W(32), .HIST_DEPTH(2), .CNT_W(16)) b0 ();
  pc_gen_pipe_if #(.ADDR_W(32), .HIST_DEPTH(2), .CNT_W(16)) b1 ();
  pc_gen_pipe_if #(.ADDR_W(32), .HIST_DEPTH(2), .CNT_W(16)) b2 ();

  pc_gen_pipe u0 (.clk(clk), .rst(rst), .bus(b0));

  pc_gen_pipe #(.ALIGN_BITS(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  pc_gen_pipe #(.RESET_VEC(32'hFFFF_FFF8)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (b0.pc_out !== 32'h0) begin
      bad++;
      $display("FAIL rst_pc got=%h want=0", b0.pc_out);
    end
    total++;
    if (b0.pc_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b want=0", b0.pc_valid);
    end
    total++;
    if (b0.hist_out !== 64'h0) begin
      bad++;
      $display("FAIL rst_hist got=%h want=0", b0.hist_out);
    end
    total++;
    if ({b0.flush, b0.misalign_err} !== 2'b00) begin
      bad++;
      $display("FAIL rst_flags got=%b%b want=00",
               b0.flush, b0.misalign_err);
    end
    total++;
    if (b0.stall_cnt !== 16'h0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d want=0", b0.stall_cnt);
    end
  endtask

  task automatic test_run();
    logic [31:0] ep [4];
    logic [31:0] e0 [4];
    logic [31:0] e1 [4];
    ep = '{32'h4, 32'h8, 32'hC, 32'h10};
    e0 = '{32'h0, 32'h4, 32'h8, 32'hC};
    e1 = '{32'h0, 32'h0, 32'h4, 32'h8};
    rst = 1'b0;
    tick();
    total++;
    if (b0.pc_valid !== 1'b1 || b0.pc_out !== 32'h0) begin
      bad++;
      $display("FAIL run_first got=%b/%h want=1/0",
               b0.pc_valid, b0.pc_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (b0.pc_out !== ep[i] ||
          b0.hist_out[31:0] !== e0[i] ||
          b0.hist_out[63:32] !== e1[i]) begin
        bad++;
        $display("FAIL run_seq%0d got=%h/%h/%h want=%h/%h/%h",
                 i, b0.pc_out, b0.hist_out[31:0],
                 b0.hist_out[63:32], ep[i], e0[i], e1[i]);
      end
    end
  endtask

  task automatic test_stall();
    b0.load       = 1'b1;
    b0.dmem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (b0.pc_out !== 32'h10 ||
          b0.hist_out !== {32'h8, 32'hC}) begin
        bad++;
        $display("FAIL stall_hold%0d got=%h/%h want=10",
                 i, b0.pc_out, b0.hist_out);
      end
    end
    b0.dmem_valid = 1'b1;
    tick();
    total++;
    if (b0.pc_out !== 32'h14 ||
        b0.hist_out !== {32'hC, 32'h10}) begin
      bad++;
      $display("FAIL stall_release got=%h/%h want=14",
               b0.pc_out, b0.hist_out);
    end
    total++;
    if (b0.stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL stall_cnt got=%0d want=3", b0.stall_cnt);
    end
    b0.load       = 1'b0;
    b0.dmem_valid = 1'b0;
  endtask

  task automatic test_redirect();
    b0.imem_ready    = 1'b0;
    b0.branch_result = 1'b1;
    b0.jalr          = 1'b1;
    b0.next_address  = 32'h40;
    tick();
    total++;
    if (b0.pc_out !== 32'h40 || b0.flush !== 1'b1) begin
      bad++;
      $display("FAIL redir_take got=%h/%b want=40/1",
               b0.pc_out, b0.flush);
    end
    total++;
    if (b0.hist_out !== {32'h10, 32'h14} ||
        b0.stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL redir_hist got=%h/%0d want=10_14/3",
               b0.hist_out, b0.stall_cnt);
    end
    b0.branch_result = 1'b0;
    b0.jalr          = 1'b0;
    b0.imem_ready    = 1'b1;
    tick();
    total++;
    if (b0.pc_out !== 32'h44 || b0.flush !== 1'b0) begin
      bad++;
      $display("FAIL redir_after got=%h/%b want=44/0",
               b0.pc_out, b0.flush);
    end
  endtask

  task automatic test_back_to_back();
    b0.next_sel     = 1'b1;
    b0.next_address = 32'h80;
    tick();
    total++;
    if (b0.pc_out !== 32'h80 || b0.flush !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got=%h/%b want=80/1",
               b0.pc_out, b0.flush);
    end
    b0.next_address = 32'hC0;
    tick();
    total++;
    if (b0.pc_out !== 32'hC0 || b0.flush !== 1'b1 ||
        b0.hist_out[31:0] !== 32'h80) begin
      bad++;
      $display("FAIL b2b_second got=%h/%b/%h want=C0/1/80",
               b0.pc_out, b0.flush, b0.hist_out[31:0]);
    end
    b0.next_sel = 1'b0;
    tick();
    total++;
    if (b0.pc_out !== 32'hC4 || b0.flush !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%h/%b want=C4/0",
               b0.pc_out, b0.flush);
    end
  endtask

  task automatic test_misalign();
    b0.imem_ready = 1'b0;
    tick();
    tick();
    total++;
    if (b0.stall_cnt !== 16'd5 || b0.pc_out !== 32'hC4) begin
      bad++;
      $display("FAIL mis_prestall got=%0d/%h want=5/C4",
               b0.stall_cnt, b0.pc_out);
    end
    b0.branch_result = 1'b1;
    b0.jalr          = 1'b1;
    b0.next_address  = 32'h41;
    tick();
    total++;
    if (b0.misalign_err !== 1'b1 || b0.pc_valid !== 1'b0 ||
        b0.pc_out !== 32'hC4 || b0.flush !== 1'b0) begin
      bad++;
      $display("FAIL mis_trap got=%b/%b/%h/%b want=1/0/C4/0",
               b0.misalign_err, b0.pc_valid,
               b0.pc_out, b0.flush);
    end
    b0.branch_result = 1'b0;
    b0.jalr          = 1'b0;
    tick();
    total++;
    if (b0.pc_out !== 32'hC4 || b0.pc_valid !== 1'b0 ||
        b0.stall_cnt !== 16'd5 || b0.misalign_err !== 1'b1) begin
      bad++;
      $display("FAIL mis_halt got=%h/%b/%0d/%b want=C4/0/5/1",
               b0.pc_out, b0.pc_valid,
               b0.stall_cnt, b0.misalign_err);
    end
  endtask

  task automatic test_reset_mid_stall();
    rst = 1'b1;
    tick();
    total++;
    if (b0.pc_out !== 32'h0 || b0.pc_valid !== 1'b0 ||
        b0.misalign_err !== 1'b0 || b0.stall_cnt !== 16'h0 ||
        b0.hist_out !== 64'h0 || b0.flush !== 1'b0) begin
      bad++;
      $display("FAIL rst2_vals got=%h/%b/%b/%0d/%h/%b",
               b0.pc_out, b0.pc_valid, b0.misalign_err,
               b0.stall_cnt, b0.hist_out, b0.flush);
    end
    b0.imem_ready = 1'b1;
    rst = 1'b0;
    tick();
    total++;
    if (b0.pc_valid !== 1'b1 || b0.pc_out !== 32'h0) begin
      bad++;
      $display("FAIL rst2_run got=%b/%h want=1/0",
               b0.pc_valid, b0.pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ew [4];
    ew = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++;
      if (b2.pc_out !== ew[i]) begin
        bad++;
        $display("FAIL wrap%0d got=%h want=%h",
                 i, b2.pc_out, ew[i]);
      end
    end
  endtask

  task automatic test_jalr_align();
    b1.jalr         = 1'b1;
    b1.next_address = 32'h101;
    b0.jalr         = 1'b1;
    b0.next_address = 32'h102;
    tick();
    total++;
    if (b1.pc_out !== 32'h100 || b1.flush !== 1'b1 ||
        b1.misalign_err !== 1'b0) begin
      bad++;
      $display("FAIL jalr_a1 got=%h/%b/%b want=100/1/0",
               b1.pc_out, b1.flush, b1.misalign_err);
    end
    total++;
    if (b0.misalign_err !== 1'b1 || b0.pc_valid !== 1'b0 ||
        b0.pc_out !== 32'hC) begin
      bad++;
      $display("FAIL jalr_a2 got=%b/%b/%h want=1/0/C",
               b0.misalign_err, b0.pc_valid, b0.pc_out);
    end
    b1.jalr = 1'b0;
    b0.jalr = 1'b0;
    tick();
    total++;
    if (b1.pc_out !== 32'h104 || b1.flush !== 1'b0) begin
      bad++;
      $display("FAIL jalr_a1_next got=%h/%b want=104/0",
               b1.pc_out, b1.flush);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    {b0.next_sel, b0.branch_result, b0.jalr} = 3'b000;
    {b1.next_sel, b1.branch_result, b1.jalr} = 3'b000;
    {b2.next_sel, b2.branch_result, b2.jalr} = 3'b000;
    b0.next_address = '0;
    b1.next_address = '0;
    b2.next_address = '0;
    {b0.load, b0.dmem_valid, b0.imem_ready} = 3'b001;
    {b1.load, b1.dmem_valid, b1.imem_ready} = 3'b001;
    {b2.load, b2.dmem_valid, b2.imem_ready} = 3'b001;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misalign();
    test_reset_mid_stall();
    test_wrap();
    test_jalr_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
